// File: rtl/pipe_skid_stage.sv
// rtl/pipe_skid_stage.sv - pipeline stage register with valid/ready, optional skid entry, flush and stall counter
module pipe_skid_stage #(
    parameter int DATA_W   = 138,
    parameter int CTRL_W   = 12,
    parameter int SKID     = 1,
    parameter int CLR_DATA = 1,
    parameter int CNT_W    = 16
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              CLR_sync,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    // State bits are {main_v, skid_v}; FULL is only reachable when SKID=1.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] main_data;
    logic [DATA_W-1:0] main_data_nxt;
    logic [CTRL_W-1:0] main_ctrl;
    logic [CTRL_W-1:0] main_ctrl_nxt;
    logic [DATA_W-1:0] skid_data;
    logic [DATA_W-1:0] skid_data_nxt;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [CTRL_W-1:0] skid_ctrl_nxt;
    logic              main_v;
    logic              skid_v;
    logic              in_fire;
    logic              out_fire;

    assign main_v   = state[1];
    assign skid_v   = state[0];

    // With a skid entry in_ready depends only on registered state; without one
    // the stage can accept whenever its single slot is empty or draining.
    assign in_ready = (SKID != 0) ? !skid_v : (!main_v || out_ready);

    assign in_fire   = in_valid && in_ready;
    assign out_fire  = main_v && out_ready;

    assign out_valid = main_v;
    assign out_data  = main_data;
    assign out_ctrl  = main_v ? main_ctrl : '0;

    // Next-state and payload movement; flush discards contents and any concurrent input.
    always_comb begin
        state_nxt     = state;
        main_data_nxt = main_data;
        main_ctrl_nxt = main_ctrl;
        skid_data_nxt = skid_data;
        skid_ctrl_nxt = skid_ctrl;
        if (CLR_sync) begin
            state_nxt     = EMPTY;
            main_ctrl_nxt = '0;
            skid_ctrl_nxt = '0;
            if (CLR_DATA != 0) begin
                main_data_nxt = '0;
                skid_data_nxt = '0;
            end
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        main_data_nxt = in_data;
                        main_ctrl_nxt = in_ctrl;
                        state_nxt     = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_data_nxt = in_data;
                        main_ctrl_nxt = in_ctrl;
                    end else if (in_fire && (SKID != 0)) begin
                        skid_data_nxt = in_data;
                        skid_ctrl_nxt = in_ctrl;
                        state_nxt     = FULL;
                    end else if (out_fire) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_data_nxt = skid_data;
                        main_ctrl_nxt = skid_ctrl;
                        state_nxt     = ONE;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                end
            endcase
        end
    end

    // State and payload registers; reset clears everything and overrides flush.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            state     <= EMPTY;
            main_data <= '0;
            main_ctrl <= '0;
            skid_data <= '0;
            skid_ctrl <= '0;
        end else begin
            state     <= state_nxt;
            main_data <= main_data_nxt;
            main_ctrl <= main_ctrl_nxt;
            skid_data <= skid_data_nxt;
            skid_ctrl <= skid_ctrl_nxt;
        end
    end

    // Saturating count of edges where a valid output was held back; flush leaves it alone.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (main_v && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
Parametrised pipeline stage register for inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB). It adds the following to a plain flop stage:
- valid/ready flow control, so downstream stalls propagate without combinational paths;
- an optional 1-entry skid buffer, so in_ready is fully registered;
- a synchronous flush that injects a NOP bubble;
- a saturating stall-cycle counter.

Parameters:
DATA_W, 138, width of datapath payload (operands, register indices, immediate, PC+4)
CTRL_W, 12, width of control payload (RegWrite, MemWrite, ALUControl, ...)
SKID, 1, 1 = 2-entry elastic (main + skid), registered in_ready; 0 = single register, in_ready combinational
CLR_DATA, 1, 1 = flush also zeroes data payload; 0 = flush zeroes control and valid only
CNT_W, 16, width of stall counter

Ports:
CLK  input  1  clock, rising edge
reset  input  1  synchronous, active-low reset
CLR_sync  input  1  synchronous flush; turns stage contents into a bubble
in_valid  input  1  upstream payload valid
in_ready  output  1  stage can accept this cycle
in_data  input  DATA_W  upstream datapath payload
in_ctrl  input  CTRL_W  upstream control payload
out_valid  output  1  stage holds valid payload
out_ready  input  1  downstream accepts this cycle
out_data  output  DATA_W  datapath payload (main register)
out_ctrl  output  CTRL_W  control payload; forced 0 when out_valid=0
stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- All state updates on rising CLK only. Reset is sampled at the clock edge; there is no asynchronous path.
- reset=0 at edge: main/skid valid=0, main/skid data=0, main/skid ctrl=0, stall_cnt=0. Reset overrides CLR_sync and any handshake.
- Transfers: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Latency: 1 cycle. Payload accepted at edge N appears on out_* after edge N when the stage was empty or draining.
- SKID=1 states are encoded by {main_v, skid_v}:
  - EMPTY(00): in_ready=1. in_fire -> ONE.
  - ONE(10): in_ready=1.
    - in_fire & out_fire: main <= in, stay ONE.
    - in_fire & !out_fire: skid <= in -> FULL.
    - !in_fire & out_fire -> EMPTY.
  - FULL(11): in_ready=0. out_fire: main <= skid, skid_v <= 0 -> ONE.
  - in_ready is a registered function (= !skid_v).
  - Order is preserved; no payload is dropped or duplicated.
- SKID=0:
  - in_ready = !out_valid | out_ready (combinational).
  - in_fire loads main; out_fire & !in_fire clears main_v.
- out_ctrl = main_v ? main_ctrl : 0. A stalled stage holds main_data/main_ctrl stable while out_ready=0.
- Flush (CLR_sync=1, reset=1):
  - main_v <= 0, skid_v <= 0, main/skid ctrl <= 0.
  - Data is zeroed if CLR_DATA=1, otherwise held.
  - Flush beats a simultaneous in_fire: the incoming payload is discarded.
  - in_ready is 1 in the following cycle.
  - stall_cnt is not affected by flush.
- stall_cnt:
  - Increments at each edge where out_valid=1 & out_ready=0.
  - Holds at 2^CNT_W-1 (saturates, no wrap).
  - Cleared only by reset.
- An empty stage ignores in_data/in_ctrl when in_valid=0. X on payload with valid=0 must not propagate to out_ctrl.
- No combinational path from in_* to out_*. With SKID=1 there is also no path from out_ready to in_ready.

Test Plan:
1. Reset then stream: reset=0 for 2 cycles, then in_valid=1 with out_ready=1 and in_data=1,2,3,4 on consecutive cycles -> out_data=1,2,3,4 one cycle later; out_valid=1 for 4 cycles; stall_cnt=0.
2. Backpressure (SKID=1): hold out_ready=0 after accepting A, offer B, C -> B goes to skid, in_ready=0, C held upstream. Release out_ready -> out sequence A, B, C, no loss; stall_cnt equals stalled cycles.
3. Flush with simultaneous input: stage FULL, CLR_sync=1 and in_valid=1 with ctrl=12'hFFF -> next cycle out_valid=0, out_ctrl=0, in_ready=1; data=0 (CLR_DATA=1) or held (CLR_DATA=0); following accepted payload emerges unaltered.
4. Reset mid-stall: FULL, stall_cnt=5, assert reset=0 for one edge -> valid bits 0, out_ctrl=0, out_data=0, stall_cnt=0. Check reset wins over concurrent CLR_sync and in_valid.
5. Counter saturation: CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt reaches 15 and stays 15.
6. SKID=0 pass-through: out_ready toggles 1,0,1 with continuous in_valid -> in_ready follows out_ready whenever out_valid=1; ordered output matches input with no duplication.
